axis_pack_result: RTL and testbench

- Output-side width converter: the inverse of the input data unpacker.
- Accepts one wide PE result row (KERNEL_SIZE sums of SUM_WIDTH bits) from the output FIFO. Serialises it LSB-first into BUS_WIDTH-bit AXI-Stream beats towards the DMA.
- Asserts tlast on the final beat of each frame of ROWS_PER_FRAME rows.

---
 rtl/axis_pack_result.sv | 109 ++++++++++
 tb/tb_axis_pack_result.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pack_result.sv
// Output-side width converter: holds one wide PE result row and streams it
// LSB-first as BUS_WIDTH-bit AXI-Stream beats, marking frame ends with tlast.
module axis_pack_result #(
  parameter int KERNEL_SIZE    = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int ROWS_PER_FRAME = 16,
  localparam int SUM_WIDTH     = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
  localparam int IN_WIDTH      = SUM_WIDTH * KERNEL_SIZE,
  localparam int BEATS         = (IN_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [BUS_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy
);

  localparam int HOLD_W = BEATS * BUS_WIDTH;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW     = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS_PER_FRAME - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_d;
  logic [BW-1:0]       beat_cnt, beat_d;
  logic [RW-1:0]       row_cnt, row_d;
  logic [HOLD_W-1:0]   hold;
  logic                load;
  logic                last_beat;

  // Zero-extend the row so the final beat is padded above IN_WIDTH.
  function automatic logic [HOLD_W-1:0] pad_row(input logic [IN_WIDTH-1:0] d);
    logic [HOLD_W-1:0] r;
    r = '0;
    r[IN_WIDTH-1:0] = d;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      row_cnt  <= '0;
      hold     <= '0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_d;
      row_cnt  <= row_d;
      if (load) hold <= pad_row(s_axis_tdata);
    end
  end

  assign last_beat = (beat_cnt == LAST_BEAT);

  // s_axis_tready depends combinationally on m_axis_tready so a new row can
  // be loaded on the cycle the last beat leaves, giving gapless streaming.
  always_comb begin
    state_d       = state;
    beat_d        = beat_cnt;
    row_d         = row_cnt;
    load          = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          load    = 1'b1;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        busy          = 1'b1;
        m_axis_tlast  = last_beat && (row_cnt == LAST_ROW);
        if (m_axis_tready) begin
          if (last_beat) begin
            row_d         = (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
              load   = 1'b1;
              beat_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_cnt + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_tdata = BUS_WIDTH'(hold >> (int'(beat_cnt) * BUS_WIDTH));

endmodule

// File: tb/tb_axis_pack_result.sv
// Directed bench for axis_pack_result: default 512->32 configuration plus a
// 57->32 instance exercising final-beat zero padding.
module tb_axis_pack_result;

  logic         clk = 1'b0;
  logic         rstn;
  logic [511:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         busy;

  logic [56:0]  s2_tdata;
  logic         s2_tvalid;
  logic         s2_tready;
  logic [31:0]  m2_tdata;
  logic         m2_tvalid;
  logic         m2_tready;
  logic         m2_tlast;
  logic         busy2;

  always #5 clk = ~clk;

  axis_pack_result dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .busy(busy)
  );

  axis_pack_result #(.KERNEL_SIZE(3)) dut2 (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
    .m_axis_tlast(m2_tlast), .busy(busy2)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pend = 0;
  int          gap = 0;
  int          gap_cnt = 0;
  int          next_k = 0;
  int          model_row = 0;
  bit          bp = 1'b0;
  int          bp_idx = 0;
  bit          hold_chk = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  int          beats, tlast_cnt, tlast_idx;
  int          first_acc, first_beat, last_beat_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] elem(input int k, input int i);
    if (k == 0) return 32'(i + 1);
    return 32'(k) * 32'h9E3779B1 ^ 32'(i) * 32'h01000193 ^ 32'(i);
  endfunction

  function automatic logic [511:0] make_row(input int k);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = elem(k, i);
    return r;
  endfunction

  task automatic cycle();
    bit    idle;
    beat_t e;
    @(negedge clk);
    m_tready = bp ? ((bp_idx % 4 == 0) || (bp_idx % 4 == 3)) : 1'b1;
    bp_idx++;
    if (pend > 0 && gap_cnt == 0) begin
      s_tvalid = 1'b1;
      s_tdata  = make_row(next_k);
    end else begin
      s_tvalid = 1'b0;
    end
    #1;
    cyc++;
    idle = (exp_q.size() == 0);
    chk("busy", busy, !idle);
    chk("m_vld", m_tvalid, !idle);
    chk("s_rdy", s_tready, idle || (exp_q.size() == 1 && m_tready));
    if (hold_chk) begin
      chk("hold_data", m_tdata, prev_data);
      chk("hold_last", m_tlast, prev_last);
    end
    hold_chk  = m_tvalid && !m_tready;
    prev_data = m_tdata;
    prev_last = m_tlast;
    if (m_tvalid && m_tready && !idle) begin
      e = exp_q.pop_front();
      chk("beat_data", m_tdata, e.data);
      chk("beat_last", m_tlast, e.last);
      beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat_cyc = cyc;
      if (m_tlast) begin
        tlast_cnt++;
        tlast_idx = beats;
      end
    end
    if (s_tvalid && s_tready) begin
      for (int j = 0; j < 16; j++) begin
        e.data = elem(next_k, j);
        e.last = (j == 15) && (model_row == 15);
        exp_q.push_back(e);
      end
      model_row = (model_row + 1) % 16;
      if (first_acc < 0) first_acc = cyc;
      pend--;
      next_k++;
      gap_cnt = gap;
    end else if (!s_tvalid && idle && gap_cnt > 0) begin
      gap_cnt--;
    end
  endtask

  task automatic run_rows(input int n, input int g, input bit use_bp, input int abort_beats);
    bit done;
    pend = n; gap = g; gap_cnt = 0; bp = use_bp; bp_idx = 0;
    beats = 0; tlast_cnt = 0; tlast_idx = 0;
    first_acc = -1; first_beat = -1; last_beat_cyc = -1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      cycle();
      if (abort_beats > 0) done = (beats >= abort_beats);
      else done = (pend == 0 && exp_q.size() == 0);
    end
    chk("run_done", done, 1'b1);
    bp = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend = 0; gap_cnt = 0; model_row = 0; hold_chk = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"}, m_tvalid, 1'b0);
    chk({tag, "_last"}, m_tlast, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_data"}, m_tdata, 32'h0);
    chk({tag, "_srdy"}, s_tready, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s2_tvalid = 1'b0; s2_tdata = '1; m2_tready = 1'b1;
    #12;
    check_reset_outputs("rst");
    @(negedge clk); rstn = 1'b1;

    // padded-width instance
    @(negedge clk); s2_tvalid = 1'b1; #1;
    chk("nm_srdy", s2_tready, 1'b1);
    chk("nm_vld0", m2_tvalid, 1'b0);
    @(negedge clk); s2_tvalid = 1'b0; #1;
    chk("nm_vld1", m2_tvalid, 1'b1);
    chk("nm_beat0", m2_tdata, 32'hFFFF_FFFF);
    chk("nm_last0", m2_tlast, 1'b0);
    @(negedge clk); #1;
    chk("nm_vld2", m2_tvalid, 1'b1);
    chk("nm_beat1", m2_tdata, 32'h01FF_FFFF);
    chk("nm_last1", m2_tlast, 1'b0);
    @(negedge clk); #1;
    chk("nm_idle", m2_tvalid, 1'b0);

    // single row
    run_rows(1, 0, 1'b0, 0);
    chk("single_lat", 32'(first_beat - first_acc), 32'd1);
    chk("single_span", 32'(last_beat_cyc - first_acc), 32'd16);
    chk("single_tlast", 32'(tlast_cnt), 32'd0);
    cycle();

    // fresh frame: 17 rows back-to-back
    @(negedge clk); s_tvalid = 1'b0; rstn = 1'b0; #1;
    check_reset_outputs("rst2");
    clear_model();
    @(negedge clk); rstn = 1'b1;
    run_rows(17, 0, 1'b0, 0);
    chk("frame_beats", 32'(beats), 32'd272);
    chk("frame_nobubble", 32'(last_beat_cyc - first_acc), 32'd272);
    chk("frame_tlast_cnt", 32'(tlast_cnt), 32'd1);
    chk("frame_tlast_idx", 32'(tlast_idx), 32'd256);

    // backpressure
    run_rows(2, 0, 1'b1, 0);
    chk("bp_beats", 32'(beats), 32'd32);

    // starvation with idle gaps
    run_rows(3, 5, 1'b0, 0);
    chk("gap_beats", 32'(beats), 32'd48);
    chk("gap_span_ge", 32'(last_beat_cyc - first_acc >= 58), 32'd1);

    // reset after beat 7 accepted
    run_rows(1, 0, 1'b0, 8);
    @(posedge clk); #1; rstn = 1'b0; #1;
    chk("mid_vld", m_tvalid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_data", m_tdata, 32'h0);
    clear_model();
    @(negedge clk); rstn = 1'b1;
    run_rows(16, 0, 1'b0, 0);
    chk("mid_tlast_cnt", 32'(tlast_cnt), 32'd1);
    chk("mid_tlast_idx", 32'(tlast_idx), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
